// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift units: FSM states, widths and shift-count type.
package shift_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef logic [SHAMT_W-1:0] shamt_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/shl_step.sv
// Single-bit left step: drops the MSB and inserts fill_i at bit 0.
module shl_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] data_i,
    input  logic             fill_i,
    output logic [Width-1:0] data_o
);

    assign data_o = {data_i[Width-2:0], fill_i};

endmodule

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter, one bit per clock, start/done handshake.
// Define SHL_ROTATE_EN to add the rotate port (rotate-left instead of zero fill).
module shift_left_sequential
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shift_amount,
`ifdef SHL_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_e           state_q, state_d;
    shamt_t           count_q, count_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] step_out;
    logic             fill;
    shamt_t           shamt_in;

    // Counts wrap modulo 2^SHAMT_W; the upper bits are deliberately dropped.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shift_amount[31:SHAMT_W];
    assign shamt_in        = shift_amount[SHAMT_W-1:0];

`ifdef SHL_ROTATE_EN
    logic rotate_q, rotate_d;
    assign fill = rotate_q & work_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    shl_step #(
        .Width (WIDTH)
    ) u_shl_step (
        .data_i (work_q),
        .fill_i (fill),
        .data_o (step_out)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        data_out_d = data_out_q;
`ifdef SHL_ROTATE_EN
        rotate_d   = rotate_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = data_in;
                    count_d = shamt_in;
`ifdef SHL_ROTATE_EN
                    rotate_d = rotate;
`endif
                    if (shamt_in == '0) begin
                        state_d    = StDone;
                        data_out_d = data_in;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d  = step_out;
                count_d = count_q - shamt_t'(1);
                // Result is published on the edge that enters DONE.
                if (count_q == shamt_t'(1)) begin
                    state_d    = StDone;
                    data_out_d = step_out;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q    <= StIdle;
            count_q    <= '0;
            work_q     <= '0;
            data_out_q <= '0;
`ifdef SHL_ROTATE_EN
            rotate_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            data_out_q <= data_out_d;
`ifdef SHL_ROTATE_EN
            rotate_q   <= rotate_d;
`endif
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign data_out = data_out_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Self-checking bench for shift_left_sequential: vector table plus handshake corner cases.
module tb_shift_left_sequential;

    logic        clk;
    logic        clear;
    logic        start;
    logic [31:0] data_in;
    logic [31:0] shift_amount;
    logic        rotate;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int passed;
    int total;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] din;
        logic [31:0] amt;
        logic        rot;
        logic [31:0] exp_d;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    shift_left_sequential dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .data_in      (data_in),
        .shift_amount (shift_amount),
`ifdef SHL_ROTATE_EN
        .rotate       (rotate),
`endif
        .busy         (busy),
        .done         (done),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    endtask

    // Drives start for one edge (E0); returns at the negedge after E0 with start low.
    task automatic issue(input logic [31:0] din, input logic [31:0] amt, input logic rot,
                         input logic [31:0] exp_d);
        @(negedge clk);
        data_in      = din;
        shift_amount = amt;
        rotate       = rot;
        start        = 1'b1;
        exp_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starting at sample cyc0 (cycle 1 = negedge after E0), waits for done and checks it.
    task automatic wait_done(input string nm, input int cyc0, input int lat);
        int          cyc;
        int          busy_cnt;
        bit          seen;
        logic [31:0] want;
        cyc      = cyc0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cyc <= 40) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        want = exp_q.pop_front();
        if (seen) begin
            check({nm, "_latency"}, 32'(cyc), 32'(lat));
            check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - cyc0 + 1));
            check({nm, "_data"}, data_out, want);
            @(negedge clk);
            check({nm, "_done_low"}, 32'(done), 32'd0);
            check({nm, "_busy_low"}, 32'(busy), 32'd0);
            check({nm, "_data_held"}, data_out, want);
        end
    endtask

    initial begin
        int pulses;
        passed       = 0;
        total        = 0;
        clear        = 1'b0;
        start        = 1'b0;
        data_in      = '0;
        shift_amount = '0;
        rotate       = 1'b0;

        vecs[0] = '{32'h0000_0005, 32'd3,  1'b0, 32'h0000_0028, 4};
        vecs[1] = '{32'hFFFF_FFFA, 32'd1,  1'b0, 32'hFFFF_FFF4, 2};
        vecs[2] = '{32'h1234_5678, 32'd0,  1'b0, 32'h1234_5678, 1};
        vecs[3] = '{32'h1234_5678, 32'd33, 1'b0, 32'h2468_ACF0, 2};
`ifdef SHL_ROTATE_EN
        vecs[4] = '{32'h8000_0001, 32'd1,  1'b1, 32'h0000_0003, 2};
        vecs[8] = '{32'hF000_0000, 32'd4,  1'b1, 32'h0000_000F, 5};
`else
        vecs[4] = '{32'h8000_0001, 32'd1,  1'b1, 32'h0000_0002, 2};
        vecs[8] = '{32'hF000_0000, 32'd4,  1'b1, 32'h0000_0000, 5};
`endif
        vecs[5] = '{32'h0000_0003, 32'd31, 1'b0, 32'h8000_0000, 32};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFE4, 1'b0, 32'hFFFF_FFF0, 5};
        vecs[7] = '{32'hDEAD_BEEF, 32'd8,  1'b0, 32'hADBE_EF00, 9};

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data", data_out, 32'd0);
        clear = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].din, vecs[i].amt, vecs[i].rot, vecs[i].exp_d);
            wait_done($sformatf("vec%0d", i), 1, vecs[i].lat);
        end

        // Clear in the middle of a long shift: the request is lost, no done appears.
        issue(32'h0000_0001, 32'd20, 1'b0, 32'h0010_0000);
        repeat (4) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_data", data_out, 32'd0);
        clear = 1'b1;
        void'(exp_q.pop_back());
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("clr_no_done", 32'(pulses), 32'd0);

        // A second start while busy must be ignored.
        issue(32'h0000_0001, 32'd4, 1'b0, 32'h0000_0010);
        data_in      = 32'hFFFF_FFFF;
        shift_amount = 32'd1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 2, 5);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("busy_start_no_extra", 32'(pulses), 32'd0);
        check("busy_start_data_kept", data_out, 32'h0000_0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
